// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the load/store requesters, the data-RAM arbiter and the RAM.
// The arbiter takes the slave view; requesters plus RAM together take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core load/store
// port and the debug/loader port, with a debug burst lock guarded by a starvation watchdog.

module dmem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic core_gnt,
    input logic dbg_gnt,
    input logic core_rvalid,
    input logic dbg_rvalid,
    input logic mem_en,
    input logic mem_we
);
    a_one_grant: assert property (@(posedge clk) disable iff (!rst) !(core_gnt && dbg_gnt));
    a_one_rvalid: assert property (@(posedge clk) disable iff (!rst) !(core_rvalid && dbg_rvalid));
    a_we_needs_en: assert property (@(posedge clk) disable iff (!rst) (mem_we |-> mem_en));
    a_en_is_grant: assert property (@(posedge clk) disable iff (!rst) (mem_en == (core_gnt || dbg_gnt)));
endmodule

module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 64,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       bus,
    output logic [15:0]         core_gnt_cnt,
    output logic [15:0]         dbg_gnt_cnt
);
    localparam logic [7:0]  MAX_LOCK_C = 8'(MAX_LOCK);
    localparam logic [7:0]  WAIT_SAT   = 8'hFF;
    localparam logic [15:0] CNT_SAT    = 16'hFFFF;

    logic              last_r;        // 0 = core won last, 1 = dbg won last
    logic              rd_pend_r;
    logic              rd_owner_r;    // 0 = core, 1 = dbg
    logic [7:0]        wait_cnt_r;
    logic [15:0]       core_cnt_r;
    logic [15:0]       dbg_cnt_r;

    logic              core_req_s;
    logic              dbg_req_s;
    logic              lock_eff_s;
    logic              core_win_s;
    logic              dbg_win_s;
    logic              rd_issue_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Requests are masked while reset is held so every output reads zero.
    assign core_req_s = bus.core_req & rst;
    assign dbg_req_s  = bus.dbg_req & rst;
    assign lock_eff_s = bus.dbg_lock & (wait_cnt_r < MAX_LOCK_C);

    // Arbitration: lock favours dbg, otherwise alternate away from the last winner.
    always_comb begin
        core_win_s = 1'b0;
        dbg_win_s  = 1'b0;
        case ({core_req_s, dbg_req_s})
            2'b11: begin
                if (lock_eff_s) begin
                    dbg_win_s = 1'b1;
                end else if (last_r) begin
                    core_win_s = 1'b1;
                end else begin
                    dbg_win_s = 1'b1;
                end
            end
            2'b10: begin
                if (lock_eff_s) begin
                    core_win_s = 1'b0;
                end else begin
                    core_win_s = 1'b1;
                end
            end
            2'b01: begin
                dbg_win_s = 1'b1;
            end
            default: begin
                core_win_s = 1'b0;
                dbg_win_s  = 1'b0;
            end
        endcase
    end

    // RAM command mux driven by the winner; write enable is forced low when idle.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.core_addr;
        mem_wdata_s = bus.core_wdata;
        if (dbg_win_s) begin
            mem_we_s    = bus.dbg_we;
            mem_addr_s  = bus.dbg_addr;
            mem_wdata_s = bus.dbg_wdata;
        end else if (core_win_s) begin
            mem_we_s    = bus.core_we;
            mem_addr_s  = bus.core_addr;
            mem_wdata_s = bus.core_wdata;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    assign rd_issue_s = (core_win_s & ~bus.core_we) | (dbg_win_s & ~bus.dbg_we);

    assign bus.core_gnt    = core_win_s;
    assign bus.dbg_gnt     = dbg_win_s;
    assign bus.core_stall  = core_req_s & ~core_win_s;
    assign bus.mem_en      = core_win_s | dbg_win_s;
    assign bus.mem_we      = mem_we_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wdata   = mem_wdata_s;
    assign bus.core_rvalid = rd_pend_r & ~rd_owner_r;
    assign bus.dbg_rvalid  = rd_pend_r & rd_owner_r;
    assign bus.core_rdata  = (rd_pend_r & ~rd_owner_r) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.dbg_rdata   = (rd_pend_r & rd_owner_r) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign core_gnt_cnt    = core_cnt_r;
    assign dbg_gnt_cnt     = dbg_cnt_r;

    // Round-robin pointer and read-return tracking; a reset drops any pending return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r     <= 1'b1;
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
        end else begin
            if (core_win_s || dbg_win_s) begin
                last_r <= dbg_win_s;
            end
            rd_pend_r <= rd_issue_s;
            if (rd_issue_s) begin
                rd_owner_r <= dbg_win_s;
            end
        end
    end

    // Starvation watchdog: counts core cycles denied under the lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 8'd0;
        end else if (core_win_s || !bus.dbg_lock) begin
            wait_cnt_r <= 8'd0;
        end else if (core_req_s && (wait_cnt_r != WAIT_SAT)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    // Saturating per-port grant counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_cnt_r <= 16'd0;
            dbg_cnt_r  <= 16'd0;
        end else begin
            if (core_win_s && (core_cnt_r != CNT_SAT)) begin
                core_cnt_r <= core_cnt_r + 16'd1;
            end
            if (dbg_win_s && (dbg_cnt_r != CNT_SAT)) begin
                dbg_cnt_r <= dbg_cnt_r + 16'd1;
            end
        end
    end

    dmem_arbiter_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .core_gnt    (core_win_s),
        .dbg_gnt     (dbg_win_s),
        .core_rvalid (bus.core_rvalid),
        .dbg_rvalid  (bus.dbg_rvalid),
        .mem_en      (bus.mem_en),
        .mem_we      (bus.mem_we)
    );
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus lock, reset-abort and saturation sequences.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic [15:0] core_gnt_cnt;
    logic [15:0] dbg_gnt_cnt;
    int          nvec;
    int          nerr;

    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(64)) bus ();

    dmem_arbiter #(.ADDR_W(7), .DATA_W(64), .MAX_LOCK(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .core_gnt_cnt (core_gnt_cnt),
        .dbg_gnt_cnt  (dbg_gnt_cnt)
    );

    // Synchronous RAM model: read data one cycle after the access, write visible next cycle.
    logic [63:0] ram [0:127];
    always_ff @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        c_req, c_we;
        logic [6:0]  c_addr;
        logic [63:0] c_wd;
        logic        d_req, d_we, d_lock;
        logic [6:0]  d_addr;
        logic [63:0] d_wd;
        logic        e_cg, e_dg, e_stall, e_en, e_we;
        logic [6:0]  e_addr;
        logic [63:0] e_wd;
        logic        e_crv;
        logic [63:0] e_crd;
        logic        e_drv;
        logic [63:0] e_drd;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, cw, input logic [6:0] ca, input logic [63:0] cd,
        input logic dr, dw, dl, input logic [6:0] da, input logic [63:0] dd,
        input logic ecg, edg, est, een, ewe, input logic [6:0] ea, input logic [63:0] ewd,
        input logic ecrv, input logic [63:0] ecrd, input logic edrv, input logic [63:0] edrd);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
        v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da; v.d_wd = dd;
        v.e_cg = ecg; v.e_dg = edg; v.e_stall = est; v.e_en = een; v.e_we = ewe;
        v.e_addr = ea; v.e_wd = ewd;
        v.e_crv = ecrv; v.e_crd = ecrd; v.e_drv = edrv; v.e_drd = edrd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.core_req   = v.c_req;
        bus.core_we    = v.c_we;
        bus.core_addr  = v.c_addr;
        bus.core_wdata = v.c_wd;
        bus.dbg_req    = v.d_req;
        bus.dbg_we     = v.d_we;
        bus.dbg_lock   = v.d_lock;
        bus.dbg_addr   = v.d_addr;
        bus.dbg_wdata  = v.d_wd;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input int idx, input vec_t v);
        logic [205:0] act;
        logic [205:0] exp;
        act = {bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.mem_en, bus.mem_we,
               bus.mem_en ? bus.mem_addr : 7'd0,
               (bus.mem_en & bus.mem_we) ? bus.mem_wdata : 64'd0,
               bus.core_rvalid, bus.core_rdata, bus.dbg_rvalid, bus.dbg_rdata};
        exp = {v.e_cg, v.e_dg, v.e_stall, v.e_en, v.e_we, v.e_addr, v.e_wd,
               v.e_crv, v.e_crd, v.e_drv, v.e_drd};
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL vec%0d: got %h want %h", idx, act, exp);
        end
    endtask

    vec_t vecs[23];
    vec_t idle_v;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int exp_c;
        int exp_d;
        nvec = 0;
        nerr = 0;
        exp_c = 0;
        exp_d = 0;

        idle_v   = mk(1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,64'h0,1'b0,64'h0);
        vecs[0]  = idle_v;
        vecs[1]  = mk(1'b1,1'b1,7'd5,64'h1234, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b1,7'd5,64'h1234, 1'b0,64'h0,1'b0,64'h0);
        vecs[2]  = mk(1'b1,1'b0,7'd5,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b0,7'd5,64'h0, 1'b0,64'h0,1'b0,64'h0);
        vecs[3]  = mk(1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,64'h1234,1'b0,64'h0);
        vecs[4]  = mk(1'b0,1'b0,7'd0,64'h0, 1'b1,1'b1,1'b0,7'd1,64'd11, 1'b0,1'b1,1'b0,1'b1,1'b1,7'd1,64'd11, 1'b0,64'h0,1'b0,64'h0);
        vecs[5]  = mk(1'b0,1'b0,7'd0,64'h0, 1'b1,1'b1,1'b0,7'd2,64'd22, 1'b0,1'b1,1'b0,1'b1,1'b1,7'd2,64'd22, 1'b0,64'h0,1'b0,64'h0);
        vecs[6]  = mk(1'b1,1'b0,7'd1,64'h0, 1'b1,1'b0,1'b0,7'd2,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b0,7'd1,64'h0, 1'b0,64'h0,1'b0,64'h0);
        vecs[7]  = mk(1'b1,1'b0,7'd1,64'h0, 1'b1,1'b0,1'b0,7'd2,64'h0, 1'b0,1'b1,1'b1,1'b1,1'b0,7'd2,64'h0, 1'b1,64'd11,1'b0,64'h0);
        vecs[8]  = mk(1'b1,1'b0,7'd1,64'h0, 1'b1,1'b0,1'b0,7'd2,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b0,7'd1,64'h0, 1'b0,64'h0,1'b1,64'd22);
        vecs[9]  = mk(1'b1,1'b0,7'd1,64'h0, 1'b1,1'b0,1'b0,7'd2,64'h0, 1'b0,1'b1,1'b1,1'b1,1'b0,7'd2,64'h0, 1'b1,64'd11,1'b0,64'h0);
        vecs[10] = mk(1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,64'h0,1'b1,64'd22);
        vecs[11] = mk(1'b1,1'b1,7'd1,64'h55, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b1,7'd1,64'h55, 1'b0,64'h0,1'b0,64'h0);
        vecs[12] = mk(1'b0,1'b0,7'd0,64'h0, 1'b1,1'b0,1'b0,7'd1,64'h0, 1'b0,1'b1,1'b0,1'b1,1'b0,7'd1,64'h0, 1'b0,64'h0,1'b0,64'h0);
        vecs[13] = mk(1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,64'h0,1'b1,64'h55);
        vecs[14] = mk(1'b1,1'b0,7'd3,64'h0, 1'b0,1'b0,1'b1,7'd0,64'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,7'd0,64'h0, 1'b0,64'h0,1'b0,64'h0);
        vecs[15] = idle_v;
        vecs[16] = mk(1'b1,1'b0,7'd5,64'h0, 1'b1,1'b0,1'b0,7'd1,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b0,7'd5,64'h0, 1'b0,64'h0,1'b0,64'h0);
        vecs[17] = mk(1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,64'h1234,1'b0,64'h0);
        vecs[18] = mk(1'b1,1'b1,7'd7,64'hAA, 1'b1,1'b1,1'b0,7'd8,64'hBB, 1'b0,1'b1,1'b1,1'b1,1'b1,7'd8,64'hBB, 1'b0,64'h0,1'b0,64'h0);
        vecs[19] = mk(1'b1,1'b1,7'd7,64'hAA, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b1,7'd7,64'hAA, 1'b0,64'h0,1'b0,64'h0);
        vecs[20] = mk(1'b0,1'b0,7'd0,64'h0, 1'b1,1'b0,1'b0,7'd8,64'h0, 1'b0,1'b1,1'b0,1'b1,1'b0,7'd8,64'h0, 1'b0,64'h0,1'b0,64'h0);
        vecs[21] = mk(1'b1,1'b0,7'd7,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,1'b0,1'b0,1'b1,1'b0,7'd7,64'h0, 1'b0,64'h0,1'b1,64'hBB);
        vecs[22] = mk(1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b1,64'hAA,1'b0,64'h0);

        // Reset with idle requesters: everything zero, nothing returns.
        rst = 1'b0;
        drive(idle_v);
        #3;
        chk_vec(-1, idle_v);
        chk("rst_cnt", {32'd0, core_gnt_cnt, dbg_gnt_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk_vec(i, vecs[i]);
            if (vecs[i].e_cg) exp_c++;
            if (vecs[i].e_dg) exp_d++;
        end
        chk("tbl_core_cnt", {48'd0, core_gnt_cnt}, 64'(exp_c));
        chk("tbl_dbg_cnt", {48'd0, dbg_gnt_cnt}, 64'(exp_d));

        // Locked burst: 16 dbg grants, then the core, and the watchdog restarts.
        @(negedge clk);
        drive(mk(1'b1,1'b0,7'd1,64'h0, 1'b1,1'b0,1'b1,7'd2,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,64'h0,1'b0,64'h0));
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 17; k++) begin
                if (k != 0) @(negedge clk);
                #1;
                chk($sformatf("lock_r%0d_c%0d", r, k), {62'd0, bus.core_gnt, bus.dbg_gnt},
                    (k == 16) ? 64'd2 : 64'd1);
            end
            @(negedge clk);
        end

        // Lock held with dbg idle: core denied for 16 cycles, then granted.
        bus.dbg_req = 1'b0;
        for (int k = 0; k < 17; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk($sformatf("lock_idle_c%0d", k), {62'd0, bus.core_gnt, bus.core_stall},
                (k == 16) ? 64'd2 : 64'd1);
        end

        // Reset lands while a core read is in flight.
        @(negedge clk);
        drive(mk(1'b1,1'b0,7'd5,64'h0, 1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,64'h0, 1'b0,64'h0,1'b0,64'h0));
        #1;
        chk("abort_gnt", {63'd0, bus.core_gnt}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("abort_rvalid", {62'd0, bus.core_rvalid, bus.dbg_rvalid}, 64'd0);
        chk("abort_cnt", {32'd0, core_gnt_cnt, dbg_gnt_cnt}, 64'd0);
        chk("abort_outs", {61'd0, bus.core_gnt, bus.core_stall, bus.mem_en}, 64'd0);
        @(negedge clk);
        #1;
        chk("abort_rvalid2", {62'd0, bus.core_rvalid, bus.dbg_rvalid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.dbg_req = 1'b1;
        bus.dbg_addr = 7'd5;
        #1;
        chk("post_rst_conflict", {62'd0, bus.core_gnt, bus.dbg_gnt}, 64'd2);
        @(negedge clk);
        bus.dbg_req = 1'b0;
        #1;
        chk("post_rst_rdata", {bus.core_rvalid ? bus.core_rdata : 64'hDEAD}, 64'h1234);
        chk("post_rst_cnt", {48'd0, core_gnt_cnt}, 64'd1);

        // Saturation of the core grant counter.
        repeat (65540) @(negedge clk);
        #1;
        chk("core_cnt_sat", {48'd0, core_gnt_cnt}, 64'hFFFF);
        chk("dbg_cnt_idle", {48'd0, dbg_gnt_cnt}, 64'd0);
        drive(idle_v);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
